// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcode/funct codes,
// instruction field bit positions, sequencer state enum and the
// illegal-instruction decode.
// Optional feature macro: DATAPATH_BRANCH_EN (enables BEQ/BNE; when
// undefined, opcodes 100/101 decode as illegal).
package datapath_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SLT = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RS_HI  = 12;
    localparam int RS_LO  = 10;
    localparam int RT_HI  = 9;
    localparam int RT_LO  = 7;
    localparam int RD_HI  = 6;
    localparam int RD_LO  = 4;
    localparam int FN_HI  = 3;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 6;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_illegal(input logic [15:0] instr);
        logic [2:0] op;
        op = instr[OP_HI:OP_LO];
        is_illegal = 1'b0;
        if (op == OP_ILL)
            is_illegal = 1'b1;
        if (op == OP_RTYPE && instr[FN_HI])
            is_illegal = 1'b1;
`ifndef DATAPATH_BRANCH_EN
        if (op == OP_BEQ || op == OP_BNE)
            is_illegal = 1'b1;
`endif
    endfunction

endpackage

// File: rtl/regfile_8xN.sv
// 8-entry register file, DATA_W bits wide.
// Ports: clk/reset (async, active-high, clears all entries), two
// combinational read ports (ra/rdata_a, rb/rdata_b), one synchronous
// write port (we/wa/wdata). r0 always reads 0 and ignores writes.
module regfile_8xN
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ra,
    input  logic [2:0]        rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++)
                regs[i] <= '0;
        end else if (we && wa != 3'd0) begin
            regs[wa] <= wdata;
        end
    end

    assign rdata_a = (ra == 3'd0) ? '0 : regs[ra];
    assign rdata_b = (rb == 3'd0) ? '0 : regs[rb];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer with an
// 8-entry register file and ALU, talking to separate instruction and
// data memories over req/ack handshakes (wait states allowed).
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_ack/
// imem_rdata (fetch); dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/
// dmem_rdata (load/store); halted, illegal, dbg_pc (status).
// Optional feature macro: DATAPATH_BRANCH_EN (BEQ/BNE support).
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] dbg_pc
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, alu_out, mdr, alu_res, simm;
    logic [DATA_W-1:0] rf_a, rf_b, rf_wdata;
    logic              illegal_q, rf_we;
    logic [2:0]        op, rs, rt, rd, rf_wa;
    logic [3:0]        funct;

    assign op    = ir[OP_HI:OP_LO];
    assign rs    = ir[RS_HI:RS_LO];
    assign rt    = ir[RT_HI:RT_LO];
    assign rd    = ir[RD_HI:RD_LO];
    assign funct = ir[FN_HI:FN_LO];
    assign simm  = {{(DATA_W-7){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};

    regfile_8xN #(.DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra      (rs),
        .rb      (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (rf_we),
        .wa      (rf_wa),
        .wdata   (rf_wdata)
    );

    // ALU: R-type uses funct, every other opcode needs rs + simm.
    always_comb begin
        alu_res = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_res = a_q + b_q;
                FN_SUB:  alu_res = a_q - b_q;
                FN_AND:  alu_res = a_q & b_q;
                FN_OR:   alu_res = a_q | b_q;
                FN_XOR:  alu_res = a_q ^ b_q;
                FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                FN_SLL:  alu_res = a_q << b_q[3:0];
                FN_SRL:  alu_res = a_q >> b_q[3:0];
                default: alu_res = '0;
            endcase
        end else begin
            alu_res = a_q + simm;
        end
    end

`ifdef DATAPATH_BRANCH_EN
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    assign br_taken  = (op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q);
    // pc already points past the branch; offset is in halfwords.
    assign br_target = pc + {{(ADDR_W-8){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO], 1'b0};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RST;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RST:    state_nx = S_FETCH;
            S_FETCH:  if (imem_ack) state_nx = S_DECODE;
            S_DECODE: begin
                if (is_illegal(ir) || op == OP_HALT)
                    state_nx = S_HALT;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
`ifdef DATAPATH_BRANCH_EN
                if (op == OP_BEQ || op == OP_BNE)
                    state_nx = S_FETCH;
                else
`endif
                if (op == OP_LW || op == OP_SW)
                    state_nx = S_MEM;
                else
                    state_nx = S_WB;
            end
            S_MEM:    if (dmem_ack) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_RST;
        endcase
    end

    always_comb begin
        imem_req = (state == S_FETCH);
        dmem_req = (state == S_MEM);
        dmem_we  = (state == S_MEM) && (op == OP_SW);
        halted   = (state == S_HALT);
        illegal  = (state == S_HALT) && illegal_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + ADDR_W'(2);
                    end
                end
                S_DECODE: begin
                    a_q       <= rf_a;
                    b_q       <= rf_b;
                    illegal_q <= is_illegal(ir);
                end
                S_EXEC: begin
                    alu_out <= alu_res;
`ifdef DATAPATH_BRANCH_EN
                    if (br_taken)
                        pc <= br_target;
`endif
                end
                S_MEM: begin
                    if (dmem_ack && op == OP_LW)
                        mdr <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign rf_we    = (state == S_WB);
    assign rf_wa    = (op == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

    assign imem_addr  = pc;
    assign dbg_pc     = pc;
    assign dmem_addr  = ADDR_W'(alu_out);
    assign dmem_wdata = b_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed programs plus
// random programs compared against an instruction-level reference model.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
    logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_pc;

    multicycle_datapath #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .illegal    (illegal),
        .dbg_pc     (dbg_pc)
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          iwait = 0;
    int          dwait = 0;
    int          stab_err = 0;
    logic [15:0] prog [256];
    logic [15:0] dut_mem [int];
    logic [15:0] mdl_mem [int];
    logic        q_we[$];
    logic [15:0] q_addr[$], q_wdata[$], q_fetch[$];
    logic        e_we[$];
    logic [15:0] e_addr[$], e_wdata[$], e_fetch[$];

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory responder: ack after iwait/dwait cycles of request.
    initial begin : responder
        int          icnt, dcnt;
        logic [15:0] h_addr, h_wdata;
        logic        h_we;
        icnt = 0; dcnt = 0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'hDEAD; dmem_ack = 1'b0; dmem_rdata = 16'hBEEF;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            imem_rdata = 16'hDEAD;
            if (imem_req === 1'b1 && !reset) begin
                if (icnt == iwait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = prog[imem_addr[8:1]];
                    q_fetch.push_back(imem_addr);
                    icnt = 0;
                end else icnt++;
            end else icnt = 0;
            if (dmem_req === 1'b1 && !reset) begin
                if (dcnt == 0) begin
                    h_addr = dmem_addr; h_we = dmem_we; h_wdata = dmem_wdata;
                end else if (dmem_addr !== h_addr || dmem_we !== h_we ||
                             (h_we && dmem_wdata !== h_wdata)) begin
                    stab_err++;
                end
                if (dcnt == dwait) begin
                    dmem_ack = 1'b1;
                    q_we.push_back(dmem_we);
                    q_addr.push_back(dmem_addr);
                    q_wdata.push_back(dmem_we ? dmem_wdata : 16'h0);
                    if (dmem_we)
                        dut_mem[int'(dmem_addr)] = dmem_wdata;
                    else
                        dmem_rdata = dut_mem.exists(int'(dmem_addr)) ?
                                     dut_mem[int'(dmem_addr)] : mem_default(dmem_addr);
                    dcnt = 0;
                end else dcnt++;
            end else dcnt = 0;
        end
    end

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4);
        for (int i = 0; i < 256; i++) prog[i] = 16'hE000;
        prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3; prog[4] = w4;
        dut_mem.delete();
        mdl_mem.delete();
    endtask

    // Reset, run until halted; cyc counts clock edges after reset release.
    task automatic run_prog(input int iw, input int dw, output int cyc, output bit tmo);
        iwait = iw; dwait = dw;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        q_we.delete(); q_addr.delete(); q_wdata.delete(); q_fetch.delete();
        stab_err = 0;
        @(negedge clk);
        reset = 1'b0;
        cyc = 0; tmo = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (halted === 1'b1) break;
            if (cyc > 3000) begin tmo = 1'b1; break; end
        end
    endtask

    // Instruction-level reference: ISA semantics plus per-instruction cycle cost.
    task automatic model_run(output int cyc, output logic [15:0] pc_o, output bit ill_o);
        logic [15:0] r [8];
        logic [15:0] pc, w, a, b, simm, res, ea;
        logic [2:0]  op, rs, rt, rd;
        logic [3:0]  fn;
        bit          done, taken;
        e_we.delete(); e_addr.delete(); e_wdata.delete(); e_fetch.delete();
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        pc = 16'h0; cyc = 1; ill_o = 1'b0; done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            w = prog[pc[8:1]];
            e_fetch.push_back(pc);
            pc = pc + 16'd2;
            cyc = cyc + 2 + iwait;
            op = w[15:13]; rs = w[12:10]; rt = w[9:7]; rd = w[6:4]; fn = w[3:0];
            a = r[rs]; b = r[rt];
            simm = {{9{w[6]}}, w[6:0]};
            case (op)
                3'd0: begin
                    if (fn > 4'd7) begin
                        ill_o = 1'b1; done = 1'b1;
                    end else begin
                        case (fn)
                            4'd0: res = a + b;
                            4'd1: res = a - b;
                            4'd2: res = a & b;
                            4'd3: res = a | b;
                            4'd4: res = a ^ b;
                            4'd5: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                            4'd6: res = a << b[3:0];
                            default: res = a >> b[3:0];
                        endcase
                        r[rd] = res;
                        cyc = cyc + 2;
                    end
                end
                3'd1: begin r[rt] = a + simm; cyc = cyc + 2; end
                3'd2: begin
                    ea = a + simm;
                    e_we.push_back(1'b0); e_addr.push_back(ea); e_wdata.push_back(16'h0);
                    r[rt] = mdl_mem.exists(int'(ea)) ? mdl_mem[int'(ea)] : mem_default(ea);
                    cyc = cyc + 3 + dwait;
                end
                3'd3: begin
                    ea = a + simm;
                    e_we.push_back(1'b1); e_addr.push_back(ea); e_wdata.push_back(b);
                    mdl_mem[int'(ea)] = b;
                    cyc = cyc + 2 + dwait;
                end
                3'd4, 3'd5: begin
`ifdef DATAPATH_BRANCH_EN
                    taken = (op == 3'd4) ? (a == b) : (a != b);
                    if (taken) pc = pc + {simm[14:0], 1'b0};
                    cyc = cyc + 1;
`else
                    taken = 1'b0;
                    ill_o = 1'b1; done = 1'b1;
`endif
                end
                3'd6: begin ill_o = 1'b1; done = 1'b1; end
                default: done = 1'b1;
            endcase
            r[0] = 16'h0;
        end
        pc_o = pc;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, halted, illegal} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl got %b want 00000", {imem_req, dmem_req, dmem_we, halted, illegal});
        end
        checks++;
        if (dbg_pc !== 16'h0 || imem_addr !== 16'h0) begin
            errors++; $display("FAIL rst_pc got %h/%h want 0000", dbg_pc, imem_addr);
        end
        checks++;
        if (dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin
            errors++; $display("FAIL rst_dmem got %h/%h want 0000", dmem_addr, dmem_wdata);
        end
        iwait = 50;
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_first_req_early got %b want 0", imem_req);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            errors++; $display("FAIL rst_first_req got %b@%h want 1@0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic(input int iw, input int want_cyc);
        int cyc; bit tmo;
        load_prog(16'h2085, 16'h217D, 16'h0530, 16'h6184, 16'hE000);
        run_prog(iw, 0, cyc, tmo);
        checks++;
        if (tmo || cyc != want_cyc) begin
            errors++; $display("FAIL basic_cycles iw=%0d got %0d want %0d", iw, cyc, want_cyc);
        end
        checks++;
        if (illegal !== 1'b0 || dbg_pc !== 16'h000A) begin
            errors++; $display("FAIL basic_halt iw=%0d got ill=%b pc=%h want ill=0 pc=000a", iw, illegal, dbg_pc);
        end
        checks++;
        if (q_we.size() != 1) begin
            errors++; $display("FAIL basic_dmem_count iw=%0d got %0d want 1", iw, q_we.size());
        end else begin
            checks++;
            if (q_we[0] !== 1'b1 || q_addr[0] !== 16'h0004 || q_wdata[0] !== 16'h0002) begin
                errors++; $display("FAIL basic_store iw=%0d got we=%b a=%h d=%h want we=1 a=0004 d=0002",
                                   iw, q_we[0], q_addr[0], q_wdata[0]);
            end
        end
    endtask

    task automatic test_lw_wait;
        int cyc; bit tmo;
        // LW r5,8(r0); SW r5,12(r0); HALT
        load_prog(16'h4288, 16'h628C, 16'hE000, 16'hE000, 16'hE000);
        dut_mem[8] = 16'h1234; mdl_mem[8] = 16'h1234;
        run_prog(0, 2, cyc, tmo);
        checks++;
        if (tmo || cyc != 16) begin
            errors++; $display("FAIL lw_cycles got %0d want 16", cyc);
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL lw_stability got %0d unstable cycles want 0", stab_err);
        end
        checks++;
        if (q_we.size() != 2) begin
            errors++; $display("FAIL lw_count got %0d want 2", q_we.size());
        end else begin
            checks++;
            if (q_we[0] !== 1'b0 || q_addr[0] !== 16'h0008) begin
                errors++; $display("FAIL lw_access got we=%b a=%h want we=0 a=0008", q_we[0], q_addr[0]);
            end
            checks++;
            if (q_addr[1] !== 16'h000C || q_wdata[1] !== 16'h1234) begin
                errors++; $display("FAIL lw_value got a=%h d=%h want a=000c d=1234", q_addr[1], q_wdata[1]);
            end
        end
    endtask

    task automatic test_branch;
        int cyc; bit tmo;
`ifdef DATAPATH_BRANCH_EN
        // BEQ r0,r0,+1 at 0 -> 4; BEQ r0,r0,-2 at 4 -> 2; HALT at 2
        load_prog(16'h8001, 16'hE000, 16'h807E, 16'hE000, 16'hE000);
        run_prog(0, 0, cyc, tmo);
        checks++;
        if (tmo || cyc != 9 || illegal !== 1'b0 || dbg_pc !== 16'h0004) begin
            errors++; $display("FAIL branch_run got cyc=%0d ill=%b pc=%h want 9/0/0004", cyc, illegal, dbg_pc);
        end
        checks++;
        if (q_fetch.size() != 3) begin
            errors++; $display("FAIL branch_fetch_count got %0d want 3", q_fetch.size());
        end else begin
            checks++;
            if (q_fetch[1] !== 16'h0004 || q_fetch[2] !== 16'h0002) begin
                errors++; $display("FAIL branch_target got %h,%h want 0004,0002", q_fetch[1], q_fetch[2]);
            end
        end
`else
        load_prog(16'h807E, 16'hE000, 16'hE000, 16'hE000, 16'hE000);
        run_prog(0, 0, cyc, tmo);
        checks++;
        if (tmo || cyc != 3 || illegal !== 1'b1 || halted !== 1'b1 || dbg_pc !== 16'h0002) begin
            errors++; $display("FAIL branch_disabled got cyc=%0d ill=%b halt=%b pc=%h want 3/1/1/0002",
                               cyc, illegal, halted, dbg_pc);
        end
`endif
    endtask

    task automatic test_illegal;
        int cyc; bit tmo;
        logic [15:0] words [2];
        words[0] = 16'h0009;  // R-type funct 9
        words[1] = 16'hC000;  // opcode 110
        for (int k = 0; k < 2; k++) begin
            load_prog(words[k], 16'hE000, 16'hE000, 16'hE000, 16'hE000);
            run_prog(1, 0, cyc, tmo);
            checks++;
            if (tmo || cyc != 4 || illegal !== 1'b1 || dbg_pc !== 16'h0002) begin
                errors++; $display("FAIL illegal_%h got cyc=%0d ill=%b pc=%h want 4/1/0002",
                                   words[k], cyc, illegal, dbg_pc);
            end
        end
        // ADDI r0,r0,7; SW r0,0(r0); HALT
        load_prog(16'h2007, 16'h6000, 16'hE000, 16'hE000, 16'hE000);
        run_prog(0, 0, cyc, tmo);
        checks++;
        if (tmo || cyc != 11 || q_wdata.size() != 1) begin
            errors++; $display("FAIL r0_run got cyc=%0d stores=%0d want 11/1", cyc, q_wdata.size());
        end else begin
            checks++;
            if (q_wdata[0] !== 16'h0000 || q_addr[0] !== 16'h0000) begin
                errors++; $display("FAIL r0_value got %h want 0000", q_wdata[0]);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int cyc, n; bit tmo;
        load_prog(16'h2085, 16'h217D, 16'h0530, 16'h6184, 16'hE000);
        iwait = 0; dwait = 10;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        n = 0;
        while (dmem_req !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL midrst_reach got dmem_req=%b want 1", dmem_req);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, halted, illegal} !== 5'b0 || dbg_pc !== 16'h0 ||
            dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin
            errors++; $display("FAIL midrst_outputs got ctl=%b pc=%h a=%h d=%h want 0",
                               {imem_req, dmem_req, dmem_we, halted, illegal}, dbg_pc, dmem_addr, dmem_wdata);
        end
        run_prog(0, 0, cyc, tmo);
        checks++;
        if (q_fetch.size() == 0 || q_fetch[0] !== 16'h0000) begin
            errors++; $display("FAIL midrst_refetch got %0d fetches first=%h want first=0000",
                               q_fetch.size(), (q_fetch.size() > 0) ? q_fetch[0] : 16'hFFFF);
        end
        checks++;
        if (tmo || cyc != 19 || q_wdata.size() != 1 || dbg_pc !== 16'h000A) begin
            errors++; $display("FAIL midrst_rerun got cyc=%0d stores=%0d pc=%h want 19/1/000a",
                               cyc, q_wdata.size(), dbg_pc);
        end
    endtask

    task automatic test_random;
        int          cyc, ecyc, n, k, bad;
        bit          tmo, eill;
        logic [15:0] epc, w;
        for (int t = 0; t < 10; t++) begin
            load_prog(16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hE000);
            n = $urandom_range(4, 14);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 3);
                w = 16'($urandom);
                w[15:13] = 3'(k);
                if (k == 0) w[3] = 1'b0;
                prog[i] = w;
            end
            if ($urandom_range(0, 3) == 0) prog[n] = 16'h000F;
            run_prog($urandom_range(0, 3), $urandom_range(0, 3), cyc, tmo);
            model_run(ecyc, epc, eill);
            checks++;
            if (tmo || cyc != ecyc) begin
                errors++; $display("FAIL rand%0d_cycles got %0d want %0d", t, cyc, ecyc);
            end
            checks++;
            if (dbg_pc !== epc || illegal !== eill) begin
                errors++; $display("FAIL rand%0d_halt got pc=%h ill=%b want pc=%h ill=%b", t, dbg_pc, illegal, epc, eill);
            end
            checks++;
            if (q_we.size() != e_we.size() || q_fetch.size() != e_fetch.size()) begin
                errors++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", t,
                                   q_we.size(), q_fetch.size(), e_we.size(), e_fetch.size());
            end else begin
                bad = 0;
                for (int i = 0; i < e_we.size(); i++)
                    if (q_we[i] !== e_we[i] || q_addr[i] !== e_addr[i] || q_wdata[i] !== e_wdata[i]) bad++;
                for (int i = 0; i < e_fetch.size(); i++)
                    if (q_fetch[i] !== e_fetch[i]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++; $display("FAIL rand%0d_traffic got %0d differing entries want 0", t, bad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, 19);
        test_basic(3, 34);
        test_lw_wait();
        test_branch();
        test_illegal();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle CPU core: fetch/decode/execute/memory/writeback sequencer, 8-entry register file and ALU. It talks to separate instruction and data memories over req/ack handshakes, so memories may insert wait states. It replaces the single-cycle 16-bit datapath and keeps the same 16-bit instruction encoding, with configurable data and address width.

## Interface
- DATA_W, 16, register/ALU/data-memory word width (≥16)
- ADDR_W, 16, PC and memory address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped (HALT or illegal instruction)
- illegal  out  1  stop caused by an illegal opcode/funct
- dbg_pc  out  ADDR_W  current pc

## Operation
- Fields: opcode[15:13], rs[12:10], rt[9:7], rd[6:4], funct[3:0], imm[6:0]. simm = imm sign-extended from bit 6 to DATA_W.
- Opcodes:
  - 000 R-type: rd ← rs op rt.
  - 001 ADDI: rt ← rs+simm.
  - 010 LW: rt ← mem[rs+simm].
  - 011 SW: mem[rs+simm] ← rt.
  - 100 BEQ, 101 BNE (macro-gated): taken when the compare holds.
  - 111 HALT.
  - 110: illegal.
- funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL by rt[3:0], 7 SRL by rt[3:0]. Funct 8–15 is illegal.
- r0 reads as 0. Writes to r0 are discarded.
- Arithmetic wraps modulo 2^DATA_W and raises no flags. dmem_addr = alu_out[ADDR_W-1:0]. pc increments by 2 and wraps modulo 2^ADDR_W.
- FSM states: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - RST → FETCH unconditionally.
  - FETCH: imem_req=1 until imem_ack. On ack: ir ← imem_rdata, pc ← pc+2, go to DECODE.
  - DECODE: A ← R[rs], B ← R[rt]. Illegal → HALT with illegal=1. HALT opcode → HALT with illegal=0.
  - EXEC: alu_out ← result. Branch: if taken, pc ← pc + (simm<<1), where pc is already pc+2; then → FETCH. LW/SW → MEM. Others → WB.
  - MEM: dmem_req=1, dmem_we=(SW), address and data held stable until dmem_ack. On ack: LW latches mdr and → WB; SW → FETCH.
  - WB: write rd (R-type) or rt (ADDI/LW), then → FETCH.
  - HALT is absorbing until reset.
- imem_req, dmem_req and dmem_we are decoded combinationally from state only. They never depend on ack in the same cycle.

## Timing
- Reset values: state RST, pc 0, all registers 0, every output 0 (dbg_pc 0).
- First imem_req rises in the cycle after reset deasserts.
- Ack may arrive in the same cycle as req (zero-wait). Each wait cycle adds one cycle.
- Zero-wait cycle counts: R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, HALT 2 (FETCH, DECODE).
- Reset mid-access drops req immediately and discards any pending writeback.
- An ack outside FETCH/MEM is ignored.
- halted/illegal are asserted from the first cycle in HALT.

## Configuration
- DATAPATH_BRANCH_EN defined: opcodes 100/101 execute as BEQ/BNE.
- DATAPATH_BRANCH_EN undefined: opcodes 100/101 are illegal (→ HALT, illegal=1), and no compare or branch adder logic is built.

## Structure
- datapath_pkg holds:
  - opcode and funct localparams
  - FSM state enum
  - field bit positions
- Sub-module: regfile_8xN, parametrised by DATA_W. It has two combinational read ports and one synchronous write port, reset to 0, with the r0 guard.

## Test plan
- Zero-wait ack; program 0x2085 (ADDI r1,r0,5), 0x217D (ADDI r2,r0,-3), 0x0530 (ADD r3,r1,r2), 0x6184 (SW r3,4(r0)), 0xE000 -> one dmem_req with addr 4, wdata 2, we 1; halted=1 at pc 0x000A; illegal=0.
- Same program with 3 wait cycles on every imem_ack -> identical memory traffic; each instruction takes 3 cycles longer.
- LW with 2-cycle dmem_ack and dmem_rdata 0x1234 -> target rt holds 0x1234. dmem_addr/we stable throughout MEM.
- With the macro defined, BEQ r0,r0,-2 (0x807E) at pc 4 -> next fetch address 2. With the macro undefined, the same word -> halted=1, illegal=1.
- Funct 9 R-type -> HALT with illegal=1. ADDI r0,r0,7 leaves r0 reading 0.
- Reset asserted while dmem_req is high -> outputs 0 in the same cycle; after release, refetch from pc 0.
